// File: rtl/mvu_act_feeder_pkg.sv
// ---------------------------------------------------------------------------
// mvau_defn : shared definitions for the MVU activation feeder slice.
//
// Contents:
//   feeder_state_t - FILL (first pass, stores the vector while it streams
//                    through) / REPLAY (later neuron folds read back the stored copy)
//   clog2_min1()   - ceil(log2(n)), never less than 1, for counter/address widths
//   is_pow2()      - selects the concatenated form of the weight address
//   DEF_*          - default geometry (SF=4, NF=2) and its derived widths
// ---------------------------------------------------------------------------
package mvau_defn;

  typedef enum logic [0:0] {
    FILL   = 1'b0,
    REPLAY = 1'b1
  } feeder_state_t;

  // A width of zero would be illegal, so degenerate folds still get one bit.
  function automatic int clog2_min1(input int n);
    int r;
    if (n <= 1) begin
      r = 1;
    end else begin
      r = $clog2(n);
    end
    return r;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

  localparam int DEF_SIMD     = 2;
  localparam int DEF_PE       = 2;
  localparam int DEF_TSRCI    = 4;
  localparam int DEF_MATRIX_W = 8;
  localparam int DEF_MATRIX_H = 4;
  localparam int DEF_SF       = DEF_MATRIX_W / DEF_SIMD;
  localparam int DEF_NF       = DEF_MATRIX_H / DEF_PE;
  localparam int DEF_SF_W     = clog2_min1(DEF_SF);
  localparam int DEF_NF_W     = clog2_min1(DEF_NF);
  localparam int DEF_ADDR_W   = clog2_min1(DEF_SF * DEF_NF);

endpackage

// File: rtl/mvu_act_feeder_if.sv
// ---------------------------------------------------------------------------
// mvu_act_feeder_if : activation stream bundle around the feeder.
//
// Signals:
//   in_v / in_rdy / in_act       - upstream activation words (valid/ready)
//   out_v / out_rdy / out_act    - words toward the PE array (valid/ready)
//   out_sf_last                  - last SIMD fold of the current neuron fold
//   out_nf_last                  - word belongs to the last neuron fold
//   out_wgt_addr                 - weight-memory address nf*SF+sf
// Modports:
//   master - environment side (drives in_v/in_act/out_rdy)
//   slave  - feeder side
// ---------------------------------------------------------------------------
interface mvu_act_feeder_if #(
  parameter int TI     = 8,
  parameter int ADDR_W = 3
) ();

  logic              in_v;
  logic              in_rdy;
  logic [TI-1:0]     in_act;
  logic              out_v;
  logic              out_rdy;
  logic [TI-1:0]     out_act;
  logic              out_sf_last;
  logic              out_nf_last;
  logic [ADDR_W-1:0] out_wgt_addr;

  modport master (
    output in_v, in_act, out_rdy,
    input  in_rdy, out_v, out_act, out_sf_last, out_nf_last, out_wgt_addr
  );

  modport slave (
    input  in_v, in_act, out_rdy,
    output in_rdy, out_v, out_act, out_sf_last, out_nf_last, out_wgt_addr
  );

endinterface

// File: rtl/mvu_act_feeder_buf.sv
// ---------------------------------------------------------------------------
// mvu_act_buf : DEPTH x W register array holding one activation vector.
//
// Ports:
//   clk     - write clock
//   i_we    - write enable
//   i_waddr - write index (SIMD fold)
//   i_wdata - word to store
//   i_raddr - read index (combinational read)
//   o_rdata - word at i_raddr
// Contents are deliberately not reset: every location is written during
// FILL before REPLAY can read it.
// ---------------------------------------------------------------------------
module mvu_act_buf #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  // Single synchronous write port.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mvu_act_feeder.sv
// ---------------------------------------------------------------------------
// mvu_act_feeder : producer-side streamer for the matrix-vector unit.
//
// Accepts one activation vector as SF = MatrixW/SIMD words, forwards each
// word to the PE array while storing it (FILL), then replays the stored copy
// for the remaining NF-1 neuron folds (REPLAY). Each output word is tagged
// with sf_last / nf_last and the weight address nf*SF+sf.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset (outputs, counters, state)
//   bus  - mvu_act_feeder_if.slave (input stream, output stream + tags)
// Output register loads only when adv = !out_v || out_rdy, so a stalled
// word holds all out_* stable.
// ---------------------------------------------------------------------------
module mvu_act_feeder
  import mvau_defn::*;
#(
  parameter int SIMD    = DEF_SIMD,
  parameter int PE      = DEF_PE,
  parameter int TSrcI   = DEF_TSRCI,
  parameter int MatrixW = DEF_MATRIX_W,
  parameter int MatrixH = DEF_MATRIX_H,
  parameter int TI      = SIMD * TSrcI
) (
  input logic            clk,
  input logic            rst,
  mvu_act_feeder_if.slave bus
);

  localparam int SF     = MatrixW / SIMD;
  localparam int NF     = MatrixH / PE;
  localparam int SF_W   = clog2_min1(SF);
  localparam int NF_W   = clog2_min1(NF);
  localparam int ADDR_W = clog2_min1(SF * NF);

  localparam logic [SF_W-1:0] SF_LAST = SF_W'(SF - 1);
  localparam logic [NF_W-1:0] NF_LAST = NF_W'(NF - 1);
  localparam logic [SF_W-1:0] SF_ONE  = SF_W'(1);
  localparam logic [NF_W-1:0] NF_ONE  = NF_W'(1);

  feeder_state_t     r_state;
  logic [SF_W-1:0]   r_sf;
  logic [NF_W-1:0]   r_nf;
  logic              r_out_v;
  logic [TI-1:0]     r_out_act;
  logic              r_sf_last;
  logic              r_nf_last;
  logic [ADDR_W-1:0] r_addr;

  logic              w_adv;
  logic              w_in_rdy;
  logic              w_we;
  logic              w_sf_wrap;
  logic              w_nf_wrap;
  logic [TI-1:0]     w_rd_data;
  logic [ADDR_W-1:0] w_addr;

  assign w_adv     = !r_out_v || bus.out_rdy;
  assign w_in_rdy  = (r_state == FILL) && w_adv;
  assign w_we      = w_in_rdy && bus.in_v;
  assign w_sf_wrap = (r_sf == SF_LAST);
  assign w_nf_wrap = (r_nf == NF_LAST);

  // In FILL nf is 0, so the same address expression yields plain sf.
  generate
    if (SF > 1 && is_pow2(SF)) begin : g_addr_cat
      assign w_addr = ADDR_W'({r_nf, r_sf});
    end else begin : g_addr_mul
      assign w_addr = ADDR_W'((32'(r_nf) * 32'(SF)) + 32'(r_sf));
    end
  endgenerate

  // During FILL the write and read indices are both sf; REPLAY only reads.
  mvu_act_buf #(
    .DEPTH (SF),
    .W     (TI),
    .AW    (SF_W)
  ) u_buf (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_sf),
    .i_wdata (bus.in_act),
    .i_raddr (r_sf),
    .o_rdata (w_rd_data)
  );

  // FSM, fold counters and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= FILL;
      r_sf      <= {SF_W{1'b0}};
      r_nf      <= {NF_W{1'b0}};
      r_out_v   <= 1'b0;
      r_out_act <= {TI{1'b0}};
      r_sf_last <= 1'b0;
      r_nf_last <= 1'b0;
      r_addr    <= {ADDR_W{1'b0}};
    end else if (w_adv) begin
      case (r_state)
        FILL: begin
          if (bus.in_v) begin
            r_out_v   <= 1'b1;
            r_out_act <= bus.in_act;
            r_sf_last <= w_sf_wrap;
            r_nf_last <= (NF == 1);
            r_addr    <= w_addr;
            if (w_sf_wrap) begin
              r_sf <= {SF_W{1'b0}};
              if (NF > 1) begin
                r_nf    <= NF_ONE;
                r_state <= REPLAY;
              end
            end else begin
              r_sf <= r_sf + SF_ONE;
            end
          end else begin
            // Nothing to load: the gap propagates to the output.
            r_out_v <= 1'b0;
          end
        end
        REPLAY: begin
          r_out_v   <= 1'b1;
          r_out_act <= w_rd_data;
          r_sf_last <= w_sf_wrap;
          r_nf_last <= w_nf_wrap;
          r_addr    <= w_addr;
          if (w_sf_wrap) begin
            r_sf <= {SF_W{1'b0}};
            if (w_nf_wrap) begin
              // Return to FILL on the last beat so the next vector
              // can be accepted in the very next cycle.
              r_nf    <= {NF_W{1'b0}};
              r_state <= FILL;
            end else begin
              r_nf <= r_nf + NF_ONE;
            end
          end else begin
            r_sf <= r_sf + SF_ONE;
          end
        end
        default: begin
          r_state <= FILL;
          r_sf    <= {SF_W{1'b0}};
          r_nf    <= {NF_W{1'b0}};
          r_out_v <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_rdy       = w_in_rdy;
  assign bus.out_v        = r_out_v;
  assign bus.out_act      = r_out_act;
  assign bus.out_sf_last  = r_sf_last;
  assign bus.out_nf_last  = r_nf_last;
  assign bus.out_wgt_addr = r_addr;

endmodule
